otter_cu_fsm: RTL
=================

OTTER_CU_FSM -- requirements
Module: otter_cu_fsm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-002 Parameter MEM_TIMEOUT, default 15, is the maximum memory-acknowledge wait in cycles before a bus-error trap.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- instrn  in  32  instruction from the fetch latch, stable from the imem_ack cycle until the next fetch
- imem_ack  in  1  instruction fetch done
- dmem_ack  in  1  data access done
- intr  in  1  level interrupt request
- mie  in  1  global interrupt enable
- mem_rden1  out  1  instruction read request
- mem_rden2  out  1  data read request
- mem_we2  out  1  data write request
- pc_write  out  1  PC update strobe
- reg_write  out  1  register-file write strobe
- csr_we  out  1  CSR write strobe
- imm_sel  out  3  immediate select: 0=I, 1=S, 2=B, 3=U, 4=J
- int_taken  out  1  interrupt entry strobe
- trap  out  1  illegal-opcode or bus-error strobe
- instret  out  32  retired-instruction count

Function
REQ-004 The state register SHALL hold one of FETCH, EXEC, MEM, WB or INTR, and all outputs except instret SHALL be decoded combinationally from the state, instrn[6:0] and the acknowledge inputs.
REQ-005 FETCH SHALL assert mem_rden1 and stay in FETCH until imem_ack=1, then go to EXEC.
REQ-006 EXEC SHALL drive imm_sel from the opcode:
- LOAD, OP_IMM, JALR, SYSTEM -> I
- STORE -> S
- BRANCH -> B
- LUI, AUIPC -> U
- JAL -> J
- any other opcode -> 0
REQ-007 In EXEC, LUI, AUIPC, JAL, JALR, OP and OP_IMM SHALL assert pc_write and reg_write for exactly one cycle.
REQ-008 In EXEC, BRANCH SHALL assert pc_write only.
REQ-009 In EXEC, SYSTEM SHALL assert pc_write, reg_write and csr_we.
REQ-010 In EXEC, LOAD and STORE SHALL go to MEM with no strobes asserted.
REQ-011 MEM SHALL hold mem_rden2 (LOAD) or mem_we2 (STORE) high until dmem_ack=1.
REQ-012 On dmem_ack in MEM, a STORE SHALL assert pc_write and go to FETCH or INTR; a LOAD SHALL go to WB.
REQ-013 WB SHALL assert reg_write and pc_write for one cycle.
REQ-014 An unrecognised opcode in EXEC SHALL assert trap and pc_write for one cycle, set no write strobes, and go to FETCH.
REQ-015 On the retiring cycle (EXEC non-memory, STORE ack, WB), the next state SHALL be INTR if intr&mie=1, else FETCH.
REQ-016 INTR SHALL assert int_taken and pc_write for one cycle, then go to FETCH.
REQ-017 A wait counter SHALL count cycles spent in FETCH or MEM without an acknowledge.
REQ-018 When the wait counter reaches MEM_TIMEOUT, the block SHALL assert trap and pc_write for one cycle, drop the request, and go to FETCH.
REQ-019 The wait counter SHALL clear on every state change.
REQ-020 An acknowledge arriving on the timeout cycle SHALL win: normal progression, no trap.
REQ-021 instret SHALL increment by 1 on every retiring cycle; traps and INTR SHALL NOT count.
REQ-022 instret SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 An acknowledge received outside its requesting state SHALL be ignored.
REQ-024 intr arriving mid-instruction SHALL be deferred to the retiring cycle.

Reset
REQ-025 While rst_n=0, all outputs, instret and the wait counter SHALL be 0, and the state SHALL be FETCH.
REQ-026 mem_rden1 SHALL assert in the first clock cycle after rst_n is released.
REQ-027 Reset asserted mid-MEM SHALL drop mem_we2 and mem_rden2 immediately, without waiting for a clock edge.

Structure
REQ-028 The opcode constants, the state encoding and the imm_sel encoding SHALL live in a shared package otter_pkg, also used by the datapath immediate mux.
REQ-029 The wait counter SHALL be a sub-module otter_wait_timer, with ports clk, rst_n, clr, run and expired.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset, then imem_ack on cycle 3 with ADDI (0x00500093) -> FETCH for 3 cycles, then EXEC with imm_sel=0, reg_write=1, pc_write=1; instret=1.
- LW, dmem_ack after 2 wait cycles -> mem_rden2 high for 3 cycles, then one WB cycle with reg_write=1; instret=1.
- SW with intr=1, mie=1 from its EXEC cycle -> mem_we2 until ack, then INTR with int_taken=1 for 1 cycle; instret=1.
- Opcode 0x7F -> trap=1 and pc_write=1 for 1 cycle, no write strobes, instret unchanged.
- No imem_ack for 15 cycles -> trap on the timeout cycle; repeat with imem_ack on cycle 15 -> no trap.
- Preload instret to 0xFFFFFFFF, retire one instruction -> instret=0.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared OTTER definitions: RV32I opcodes, control-unit states and the
// immediate-select encoding used by the control unit and the datapath immediate mux.
package otter_pkg;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      EXEC  = 3'd1,
      MEM   = 3'd2,
      WB    = 3'd3,
      INTR  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0,
      IMM_S = 3'd1,
      IMM_B = 3'd2,
      IMM_U = 3'd3,
      IMM_J = 3'd4
   } imm_sel_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // R-type and unknown opcodes have no immediate and fall back to encoding 0
   function automatic imm_sel_t imm_sel_of(input logic [6:0] opcode);
      imm_sel_t sel;
      sel = IMM_I;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: sel = IMM_I;
         OP_STORE:                            sel = IMM_S;
         OP_BRANCH:                           sel = IMM_B;
         OP_LUI, OP_AUIPC:                    sel = IMM_U;
         OP_JAL:                              sel = IMM_J;
         default:                             sel = IMM_I;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/otter_wait_timer.sv
// Counts consecutive cycles spent waiting on a memory acknowledge; expired
// flags the cycle on which the wait reaches TIMEOUT cycles.
module otter_wait_timer
   import otter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] count;

   // count holds the completed wait cycles, so the current cycle is count+1
   assign expired = run && (count == W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (run) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control unit: sequences fetch/execute/memory/writeback,
// handles interrupts, illegal opcodes and memory timeouts, and counts retirements.
module otter_cu_fsm
   import otter_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instrn,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        intr,
   input  logic        mie,
   output logic        mem_rden1,
   output logic        mem_rden2,
   output logic        mem_we2,
   output logic        pc_write,
   output logic        reg_write,
   output logic        csr_we,
   output logic [2:0]  imm_sel,
   output logic        int_taken,
   output logic        trap,
   output logic [31:0] instret
);

   state_t      state, state_nxt;
   logic [6:0]  opcode;
   logic        retire, run, clr, expired;
   logic [31:0] instret_q;
   logic        d_rden1, d_rden2, d_we2, d_pcw, d_rw, d_csr, d_int, d_trap;
   imm_sel_t    d_imm;
   logic        unused_instrn;

   assign opcode        = instrn[6:0];
   assign unused_instrn = ^instrn[31:7];

   assign run = ((state == FETCH) && !imem_ack) || ((state == MEM) && !dmem_ack);
   assign clr = (state_nxt != state) || expired;

   otter_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .run     (run),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      d_rden1   = 1'b0;
      d_rden2   = 1'b0;
      d_we2     = 1'b0;
      d_pcw     = 1'b0;
      d_rw      = 1'b0;
      d_csr     = 1'b0;
      d_int     = 1'b0;
      d_trap    = 1'b0;
      d_imm     = IMM_I;
      retire    = 1'b0;
      case (state)
         FETCH: begin
            if (imem_ack) begin
               d_rden1   = 1'b1;
               state_nxt = EXEC;
            end else if (expired) begin
               d_trap = 1'b1;
               d_pcw  = 1'b1;
            end else begin
               d_rden1 = 1'b1;
            end
         end
         EXEC: begin
            d_imm = imm_sel_of(opcode);
            case (opcode)
               OP_LOAD, OP_STORE: state_nxt = MEM;
               OP_BRANCH: begin
                  d_pcw  = 1'b1;
                  retire = 1'b1;
               end
               OP_SYSTEM: begin
                  d_pcw  = 1'b1;
                  d_rw   = 1'b1;
                  d_csr  = 1'b1;
                  retire = 1'b1;
               end
               OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_IMM: begin
                  d_pcw  = 1'b1;
                  d_rw   = 1'b1;
                  retire = 1'b1;
               end
               default: begin
                  d_trap    = 1'b1;
                  d_pcw     = 1'b1;
                  state_nxt = FETCH;
               end
            endcase
         end
         MEM: begin
            // an acknowledge on the expiry cycle completes the access normally
            if (opcode == OP_STORE) begin
               if (dmem_ack) begin
                  d_we2  = 1'b1;
                  d_pcw  = 1'b1;
                  retire = 1'b1;
               end else if (expired) begin
                  d_trap    = 1'b1;
                  d_pcw     = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  d_we2 = 1'b1;
               end
            end else if (opcode == OP_LOAD) begin
               if (dmem_ack) begin
                  d_rden2   = 1'b1;
                  state_nxt = WB;
               end else if (expired) begin
                  d_trap    = 1'b1;
                  d_pcw     = 1'b1;
                  state_nxt = FETCH;
               end else begin
                  d_rden2 = 1'b1;
               end
            end else begin
               state_nxt = FETCH;
            end
         end
         WB: begin
            d_rw   = 1'b1;
            d_pcw  = 1'b1;
            retire = 1'b1;
         end
         INTR: begin
            d_int     = 1'b1;
            d_pcw     = 1'b1;
            state_nxt = FETCH;
         end
         default: state_nxt = FETCH;
      endcase
      // pending interrupts are only taken once the current instruction retires
      if (retire) begin
         state_nxt = (intr && mie) ? INTR : FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= '0;
      end else if (retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   // outputs are forced low combinationally so reset drops requests without a clock
   assign mem_rden1 = rst_n & d_rden1;
   assign mem_rden2 = rst_n & d_rden2;
   assign mem_we2   = rst_n & d_we2;
   assign pc_write  = rst_n & d_pcw;
   assign reg_write = rst_n & d_rw;
   assign csr_we    = rst_n & d_csr;
   assign int_taken = rst_n & d_int;
   assign trap      = rst_n & d_trap;
   assign imm_sel   = rst_n ? d_imm : 3'd0;
   assign instret   = instret_q;

endmodule
